// File: rtl/deadtime_gen_if.sv
// rtl/deadtime_gen_if.sv - command/status bundle between PWM source and dead-time gate driver
interface deadtime_gen_if #(
  parameter int DT_WIDTH = 8
);
  // Command side, driven by the PWM/control logic
  logic                enable;
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dead_time;
  logic                fault;
  logic                fault_clr;

  // Gate-drive side, driven by the dead-time generator
  logic                gate_hi;
  logic                gate_lo;
  logic                in_deadtime;
  logic                fault_latched;

  modport master (
    output enable, pwm_in, dead_time, fault, fault_clr,
    input  gate_hi, gate_lo, in_deadtime, fault_latched
  );

  modport slave (
    input  enable, pwm_in, dead_time, fault, fault_clr,
    output gate_hi, gate_lo, in_deadtime, fault_latched
  );
endinterface

// File: rtl/deadtime_gen.sv
// rtl/deadtime_gen.sv - complementary half-bridge gate driver with dead time and fault latch
module deadtime_gen #(
  parameter int DT_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  deadtime_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_DT_RISE = 3'd1,
    S_HI      = 3'd2,
    S_DT_FALL = 3'd3,
    S_LO      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                fault_latched_q, fault_latched_d;
  logic                gate_hi_q, gate_hi_d;
  logic                gate_lo_q, gate_lo_d;
  logic                in_dt_q, in_dt_d;

  // Loading a dead time of 0 behaves like 1: the "cnt <= 1" exit test
  // fires on the first edge after entry either way, so no clamp is needed.
  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  // Next-state, counter, fault latch and decoded gate outputs
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fault_latched_d = fault_latched_q;

    // A simultaneous fault and clear leaves the latch set
    if (bus.fault) begin
      fault_latched_d = 1'b1;
    end else if (bus.fault_clr) begin
      fault_latched_d = 1'b0;
    end

    // The current (pre-clear) latch value holds the bridge off for the
    // clearing edge too, so re-entry always starts from OFF with a full gap.
    if (bus.fault || fault_latched_q || !bus.enable) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = bus.pwm_in ? S_DT_RISE : S_DT_FALL;
          cnt_d   = bus.dead_time;
        end
        S_HI: begin
          if (!bus.pwm_in) begin
            state_d = S_DT_FALL;
            cnt_d   = bus.dead_time;
          end
        end
        S_LO: begin
          if (bus.pwm_in) begin
            state_d = S_DT_RISE;
            cnt_d   = bus.dead_time;
          end
        end
        S_DT_RISE: begin
          // A command reversal mid-gap restarts the both-off interval
          if (!bus.pwm_in) begin
            state_d = S_DT_FALL;
            cnt_d   = bus.dead_time;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = S_HI;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DT_FALL: begin
          if (bus.pwm_in) begin
            state_d = S_DT_RISE;
            cnt_d   = bus.dead_time;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = S_LO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end

    // Gates decode from a single state value, so they are mutually exclusive
    gate_hi_d = (state_d == S_HI);
    gate_lo_d = (state_d == S_LO);
    in_dt_d   = (state_d == S_DT_RISE) || (state_d == S_DT_FALL);
  end

  // State, counter, latch and registered outputs; reset drops gates at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_OFF;
      cnt_q           <= '0;
      fault_latched_q <= 1'b0;
      gate_hi_q       <= 1'b0;
      gate_lo_q       <= 1'b0;
      in_dt_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fault_latched_q <= fault_latched_d;
      gate_hi_q       <= gate_hi_d;
      gate_lo_q       <= gate_lo_d;
      in_dt_q         <= in_dt_d;
    end
  end

  assign bus.gate_hi       = gate_hi_q;
  assign bus.gate_lo       = gate_lo_q;
  assign bus.in_deadtime   = in_dt_q;
  assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_deadtime_gen.sv
// tb/tb_deadtime_gen.sv - scoreboard bench for deadtime_gen against a gap-countdown reference model
module tb_deadtime_gen;
  localparam int DTW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deadtime_gen_if #(.DT_WIDTH(DTW)) bus ();

  deadtime_gen #(.DT_WIDTH(DTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic hi;
    logic lo;
    logic dt;
    logic fl;
    int   gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  // Reference model: mode 0 = off, 1 = both-off gap, 2 = conducting.
  // side is the requested/conducting side (1 = high), rem the gap cycles left.
  int   m_mode;
  logic m_side;
  int   m_rem;
  int   m_gap;
  logic m_latch;

  task automatic model_reset();
    m_mode  = 0;
    m_side  = 1'b0;
    m_rem   = 0;
    m_gap   = 1;
    m_latch = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic pwm, input int dt,
                            input logic f, input logic fc);
    logic old_latch;
    old_latch = m_latch;
    m_latch   = f ? 1'b1 : (fc ? 1'b0 : old_latch);
    if (f || old_latch || !en) begin
      m_mode = 0;
    end else if (m_mode == 0 || pwm != m_side) begin
      m_mode = 1;
      m_side = pwm;
      m_gap  = (dt < 1) ? 1 : dt;
      m_rem  = m_gap;
    end else if (m_mode == 1) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_mode = 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, end at the next falling edge
  task automatic cycle(input logic en, input logic pwm, input int dt,
                       input logic f, input logic fc);
    exp_t e;
    bus.enable    = en;
    bus.pwm_in    = pwm;
    bus.dead_time = DTW'(dt);
    bus.fault     = f;
    bus.fault_clr = fc;
    @(posedge clk);
    model_step(en, pwm, dt, f, fc);
    e.hi  = (m_mode == 2) && m_side;
    e.lo  = (m_mode == 2) && !m_side;
    e.dt  = (m_mode == 1);
    e.fl  = m_latch;
    e.gap = m_gap;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    int   off_run   = 0;
    int   last_side = -1;
    forever begin
      @(negedge clk);
      chk("no_shoot_through", 32'(bus.gate_hi & bus.gate_lo), 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gate_hi", 32'(bus.gate_hi), 32'(e.hi));
        chk("gate_lo", 32'(bus.gate_lo), 32'(e.lo));
        chk("in_deadtime", 32'(bus.in_deadtime), 32'(e.dt));
        chk("fault_latched", 32'(bus.fault_latched), 32'(e.fl));
        if (bus.gate_hi) begin
          if (last_side == 0) chk("gap_lo_to_hi", 32'(off_run >= e.gap), 32'd1);
          last_side = 1;
          off_run   = 0;
        end else if (bus.gate_lo) begin
          if (last_side == 1) chk("gap_hi_to_lo", 32'(off_run >= e.gap), 32'd1);
          last_side = 0;
          off_run   = 0;
        end else begin
          off_run++;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {28'd0, bus.gate_hi, bus.gate_lo, bus.in_deadtime, bus.fault_latched}, 32'd0);
  endtask

  initial begin
    logic r_en, r_pwm, r_f, r_fc;
    int   r_dt;

    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.pwm_in    = 1'b0;
    bus.dead_time = '0;
    bus.fault     = 1'b0;
    bus.fault_clr = 1'b0;
    model_reset();

    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_state");

    // Release with enable low: stays off
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b1, 3, 1'b0, 1'b0);

    // Startup into HI with dead_time 3
    repeat (6) cycle(1'b1, 1'b1, 3, 1'b0, 1'b0);
    // HI -> LO with dead_time 3
    repeat (5) cycle(1'b1, 1'b0, 3, 1'b0, 1'b0);
    // LO -> HI with dead_time 0 (acts as 1)
    repeat (3) cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
    // HI -> LO, dead_time changed to 10 mid-interval
    cycle(1'b1, 1'b0, 3, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 10, 1'b0, 1'b0);
    // Glitch: back to HI, then a short low pulse swallowed by dead_time 4
    repeat (7) cycle(1'b1, 1'b1, 4, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 4, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b1, 4, 1'b0, 1'b0);
    // Fault in LO, clear-with-fault, then clear and re-entry
    repeat (5) cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 2, 1'b1, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
    // Enable falling mid-gap and mid-conduction
    repeat (4) cycle(1'b1, 1'b1, 5, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 5, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b1, 5, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 5, 1'b0, 1'b0);

    // Asynchronous reset in the middle of HI
    repeat (6) cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_reset_mid_hi");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b1, 2, 1'b0, 1'b0);

    // Random stress
    r_pwm = 1'b0;
    r_dt  = 3;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 7) == 0) r_pwm = ~r_pwm;
      r_en = ($urandom_range(0, 199) != 0);
      r_f  = ($urandom_range(0, 299) == 0);
      r_fc = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        if ($urandom_range(0, 9) == 0) r_dt = int'($urandom_range(0, 255));
        else r_dt = int'($urandom_range(0, 6));
      end
      cycle(r_en, r_pwm, r_dt, r_f, r_fc);
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
